// File: rtl/mtl_lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mtl_lcd_pkg
//  Purpose  : MTL panel raster timing constants, RGB type and NES 2C02 palette.
//  Revision : 1.0 - initial release
// ============================================================================
package mtl_lcd_pkg;

    typedef logic [23:0] rgb24_t;

    localparam int H_TOTAL     = 1056;
    localparam int V_TOTAL     = 525;
    localparam int HSYNC_W     = 30;
    localparam int VSYNC_W     = 13;
    localparam int H_ACT_START = 50;
    localparam int V_ACT_START = 23;
    localparam int H_ACT       = 800;
    localparam int V_ACT       = 480;
    localparam int NES_X_OFS   = 16;
    localparam int NES_W_SCALED = 768;
    localparam rgb24_t BORDER_RGB = 24'h000000;

    localparam rgb24_t NES_PALETTE [64] = '{
        24'h666666, 24'h002A88, 24'h1412A7, 24'h3B00A4, 24'h5C007E, 24'h6E0040, 24'h6C0600, 24'h561D00,
        24'h333500, 24'h0B4800, 24'h005200, 24'h004F08, 24'h00404D, 24'h000000, 24'h000000, 24'h000000,
        24'hADADAD, 24'h155FD9, 24'h4240FF, 24'h7527FE, 24'hA01ACC, 24'hB71E7B, 24'hB53120, 24'h994E00,
        24'h6B6D00, 24'h388700, 24'h0C9300, 24'h008F32, 24'h007C8D, 24'h000000, 24'h000000, 24'h000000,
        24'hFFFEFF, 24'h64B0FF, 24'h9290FF, 24'hC676FF, 24'hF36AFF, 24'hFE6ECC, 24'hFE8170, 24'hEA9E22,
        24'hBCBE00, 24'h88D800, 24'h5CE430, 24'h45E082, 24'h48CDDE, 24'h4F4F4F, 24'h000000, 24'h000000,
        24'hFFFEFF, 24'hC0DFFF, 24'hD3D2FF, 24'hE8C8FF, 24'hFBC2FF, 24'hFEC4EA, 24'hFECCC5, 24'hF7D8A5,
        24'hE4E594, 24'hCFEF96, 24'hBDF4AB, 24'hB3F3CC, 24'hB5EBF2, 24'hB8B8B8, 24'h000000, 24'h000000
    };

endpackage
`default_nettype wire

// File: rtl/nes_palette_lut.sv
`default_nettype none
// ============================================================================
//  Module   : nes_palette_lut
//  Purpose  : 6-bit NES palette index to registered 24-bit RGB, 1-cycle latency.
//  Revision : 1.0 - initial release
// ============================================================================
module nes_palette_lut
    import mtl_lcd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [5:0] i_idx,
    output rgb24_t     o_rgb
);

    rgb24_t rgb_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= NES_PALETTE[i_idx];
        end
    end

    assign o_rgb = rgb_q;

endmodule
`default_nettype wire

// File: rtl/mtl_lcd_tx.sv
`default_nettype none
// ============================================================================
//  Module   : mtl_lcd_tx
//  Purpose  : MTL panel raster/sync generator with 3x2 NES frame upscaling.
//  Revision : 1.0 - initial release
// ============================================================================
module mtl_lcd_tx
    import mtl_lcd_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rstn,
    output logic [15:0] o_fb_addr,
    output logic        o_fb_rd,
    input  logic [5:0]  i_fb_data,
    output logic        o_hsd,
    output logic        o_vsd,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic        o_frame_start,
    output logic        o_vblank
);

    localparam int WIN_START = H_ACT_START + NES_X_OFS;
    localparam int WIN_END   = WIN_START + NES_W_SCALED;

    // Raster position whose outputs are registered on the next edge.
    logic [10:0] h_q, h_d;
    logic [9:0]  v_q, v_d;

    logic [1:0]  sub_q, sub_d;
    logic [7:0]  nx_q, nx_d;
    logic        rd_q;
    logic [15:0] addr_q;
    logic        fb_vld_q;
    logic [5:0]  idx_q;

    logic        hsd_q, vsd_q, fs_q, vblank_q, act_q, pic_q;

    logic        w_h_last, w_v_last, w_v_act, w_h_act, w_win, w_fwin, w_rd;
    logic [7:0]  w_nes_y;
    logic [5:0]  w_idx;
    rgb24_t      w_lut_rgb;
    rgb24_t      w_rgb;

    assign w_h_last = (h_q == 11'(H_TOTAL - 1));
    assign w_v_last = (v_q == 10'(V_TOTAL - 1));
    assign w_v_act  = (v_q >= 10'(V_ACT_START)) && (v_q < 10'(V_ACT_START + V_ACT));
    assign w_h_act  = (h_q >= 11'(H_ACT_START)) && (h_q < 11'(H_ACT_START + H_ACT));
    assign w_win    = w_v_act && (h_q >= 11'(WIN_START)) && (h_q < 11'(WIN_END));
    // The fetch stage works on column h+2; the window never touches line wrap.
    assign w_fwin   = w_v_act && (h_q >= 11'(WIN_START - 2)) && (h_q < 11'(WIN_END - 2));
    assign w_rd     = w_fwin && (sub_q == 2'd0);
    assign w_nes_y  = 8'((v_q - 10'(V_ACT_START)) >> 1);
    assign w_idx    = fb_vld_q ? i_fb_data : idx_q;

    always_comb begin
        h_d = h_q + 11'd1;
        v_d = v_q;
        if (w_h_last) begin
            h_d = '0;
            v_d = w_v_last ? '0 : v_q + 10'd1;
        end
    end

    // Sub-counter and nes_x are cleared outside the window, so every line restarts at x=0.
    always_comb begin
        sub_d = '0;
        nx_d  = '0;
        if (w_fwin) begin
            if (sub_q == 2'd2) begin
                sub_d = '0;
                nx_d  = nx_q + 8'd1;
            end else begin
                sub_d = sub_q + 2'd1;
                nx_d  = nx_q;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            h_q      <= '0;
            v_q      <= '0;
            sub_q    <= '0;
            nx_q     <= '0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            fb_vld_q <= 1'b0;
            idx_q    <= '0;
            hsd_q    <= 1'b1;
            vsd_q    <= 1'b1;
            fs_q     <= 1'b0;
            vblank_q <= 1'b1;
            act_q    <= 1'b0;
            pic_q    <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            sub_q    <= sub_d;
            nx_q     <= nx_d;
            rd_q     <= w_rd;
            if (w_rd) begin
                addr_q <= {w_nes_y, nx_q};
            end
            fb_vld_q <= rd_q;
            idx_q    <= w_idx;
            hsd_q    <= (h_q >= 11'(HSYNC_W));
            vsd_q    <= (v_q >= 10'(VSYNC_W));
            fs_q     <= (h_q == '0) && (v_q == '0);
            vblank_q <= !w_v_act;
            act_q    <= w_v_act && w_h_act;
            pic_q    <= w_win;
        end
    end

    nes_palette_lut u_lut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_idx  (w_idx),
        .o_rgb  (w_lut_rgb)
    );

    // Final select between two registered sources keeps RGB aligned with the LUT stage.
    assign w_rgb = pic_q ? w_lut_rgb : (act_q ? BORDER_RGB : 24'h000000);

    assign o_fb_addr     = addr_q;
    assign o_fb_rd       = rd_q;
    assign o_hsd         = hsd_q;
    assign o_vsd         = vsd_q;
    assign o_frame_start = fs_q;
    assign o_vblank      = vblank_q;
    assign o_r           = w_rgb[23:16];
    assign o_g           = w_rgb[15:8];
    assign o_b           = w_rgb[7:0];

endmodule
`default_nettype wire
